fetch_pc_sequencer: RTL and testbench

Program-counter and fetch sequencer that sits directly upstream of instruction_fetch's synchronous instruction memory (1-cycle read latency). Generates byte addresses and tracks in-flight reads. Captures returned instruction words with their PC into a small flushable buffer, and presents {pc, instr} to decode/control_unit over a valid/ready handshake. Accepts branch/jump redirects from execute and flushes all younger work.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_buffer.sv | 66 ++++++
 rtl/fetch_pc_sequencer.sv | 131 +++++++++++++
 tb/tb_fetch_pc_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch PC sequencer: FSM states, PC step, NOP encoding, buffered entry.
// Pure declarations; no timing or flow-control behaviour of its own.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    TRAP
  } state_t;

  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry FIFO of fetch entries with synchronous flush; head is visible combinationally.
// Push is accepted when not full or when popping in the same cycle; flush drops everything.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  fetch_entry_t                 push_entry,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign head    = mem[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_q] <= push_entry;
        wr_q      <= ptr_next(wr_q);
      end
      if (do_pop) begin
        rd_q <= ptr_next(rd_q);
      end
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// PC/fetch sequencer for a 1-cycle imem: request C -> out_valid C+2, redirect N -> target out N+3.
// out_ready=0 fills the buffer then stalls requests; FETCH_MISALIGN_TRAP_EN adds misaligned-redirect traps.
module fetch_pc_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BUF_DEPTH    = 3
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        out_misalign
`endif
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  state_t        state_q;
  logic [31:0]   pc_q;
  logic [31:0]   pending_pc_q;
  logic          pending_q;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          unused_full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          misalign_redirect;
  logic          trap_push;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        trap_push_q;
  logic [31:0] trap_pc_q;

  assign misalign_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign trap_push         = trap_push_q && !redirect_valid;
  assign out_misalign      = !empty && head.misalign;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trap_push_q <= 1'b0;
      trap_pc_q   <= '0;
    end else begin
      trap_push_q <= misalign_redirect;
      if (misalign_redirect) begin
        trap_pc_q <= redirect_pc;
      end
    end
  end
`else
  logic unused_misalign;

  assign misalign_redirect = 1'b0;
  assign trap_push         = 1'b0;
  assign unused_misalign   = head.misalign;
`endif

  // In-flight read reserves a slot; a same-cycle pop is deliberately not credited.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, pending_q};
  assign imem_req  = (state_q == RUN) && !redirect_valid && (occupancy < (CW+1)'(BUF_DEPTH));
  assign imem_addr = pc_q;
  assign out_valid = !empty;
  assign pop       = !empty && out_ready;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  always_comb begin
    push       = trap_push || (pending_q && !redirect_valid);
    push_entry = '{pc: pending_pc_q, instr: imem_rdata, misalign: 1'b0};
    if (trap_push) begin
      push_entry = '{pc: trap_pc_q_or_zero(), instr: INSTR_NOP, misalign: 1'b1};
    end
  end

  function automatic logic [31:0] trap_pc_q_or_zero();
`ifdef FETCH_MISALIGN_TRAP_EN
    return trap_pc_q;
`else
    return 32'h0;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      pending_q    <= 1'b0;
      pending_pc_q <= RESET_VECTOR;
    end else begin
      pending_q <= imem_req;
      if (imem_req) begin
        pending_pc_q <= pc_q;
        pc_q         <= pc_q + PC_INC;
      end
      if (redirect_valid) begin
        pc_q    <= redirect_pc & ~32'h3;
        state_q <= misalign_redirect ? TRAP : RUN;
      end else if (state_q == BOOT) begin
        state_q <= RUN;
      end
    end
  end

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count),
    .full      (unused_full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench: stimulus pushes expected {pc, instr} entries; a negedge monitor pops and compares each transfer.
module tb_fetch_pc_sequencer;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        act_mis;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;
  exp_t sb[$];

`ifdef FETCH_MISALIGN_TRAP_EN
  logic out_misalign;
  assign act_mis = out_misalign;
`else
  assign act_mis = 1'b0;
`endif

  fetch_pc_sequencer #(
    .RESET_VECTOR(32'h0000_0000),
    .BUF_DEPTH   (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .out_misalign  (out_misalign)
`endif
  );

  always #5 clk = ~clk;

  // Memory holds word i at byte address 4i, returned one cycle after the request.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr >> 2) : 32'hDEAD_BEEF;
  end

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      exp_t e;
      xfers++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL xfer_unexpected got pc=%h instr=%h want=no transfer", out_pc, out_instr);
      end else begin
        e = sb.pop_front();
        if (out_pc !== e.pc || out_instr !== e.instr || act_mis !== e.mis) begin
          failures++;
          $display("FAIL xfer got pc=%h instr=%h mis=%b want pc=%h instr=%h mis=%b",
                   out_pc, out_instr, act_mis, e.pc, e.instr, e.mis);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      exp_t e;
      pc      = start + 32'(4 * i);
      e.pc    = pc;
      e.instr = pc >> 2;
      e.mis   = 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic do_release();
    sb.delete();
    push_stream(32'h0, 200);
    step();
    rst = 1'b1;
    #1;
    chk("boot_no_req", 32'(imem_req), 32'd0);
    step();
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    step();
    #1;
    chk("lat_c1_invalid", 32'(out_valid), 32'd0);
    step();
    #1;
    chk("lat_c2_valid", 32'(out_valid), 32'd1);
    chk("lat_c2_pc", out_pc, 32'h0);
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int x0;
    repeat (3) step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);

    do_release();
    x0 = xfers;
    repeat (8) step();
    chk("throughput", 32'(xfers - x0), 32'd8);

    // Backpressure: buffer fills and requests stop.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i >= 2) begin
        chk("bp_no_req", 32'(imem_req), 32'd0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_head_stable", out_pc, sb[0].pc);
      end
      step();
    end
    out_ready = 1'b1;
    x0 = xfers;
    repeat (6) step();
    chk("bp_resume_gapless", 32'(xfers - x0), 32'd6);
    repeat (3) step();

    // Redirect to 0x100 with two entries buffered and one read in flight.
    out_ready = 1'b0;
    step();
    redirect(32'h0000_0100);
    #1;
    chk("rd100_no_req_n", 32'(imem_req), 32'd0);
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    sb.delete();
    push_stream(32'h0000_0100, 100);
    #1;
    chk("rd100_req_n1", 32'(imem_req), 32'd1);
    chk("rd100_addr_n1", imem_addr, 32'h0000_0100);
    chk("rd100_flushed_n1", 32'(out_valid), 32'd0);
    step();
    #1;
    chk("rd100_invalid_n2", 32'(out_valid), 32'd0);
    step();
    #1;
    chk("rd100_valid_n3", 32'(out_valid), 32'd1);
    chk("rd100_pc_n3", out_pc, 32'h0000_0100);
    repeat (4) step();

    // Redirect coincident with a head handshake, target wraps through zero.
    x0 = xfers;
    redirect(32'hFFFF_FFF8);
    step();
    redirect_valid = 1'b0;
    chk("rd_wrap_head_once", 32'(xfers - x0), 32'd1);
    sb.delete();
    push_stream(32'hFFFF_FFF8, 100);
    repeat (8) step();

    // Back-to-back redirects: only the second stream may appear.
    redirect(32'h0000_0040);
    step();
    redirect(32'h0000_0080);
    sb.delete();
    #1;
    chk("b2b_no_req", 32'(imem_req), 32'd0);
    step();
    redirect_valid = 1'b0;
    sb.delete();
    push_stream(32'h0000_0080, 100);
    #1;
    chk("b2b_addr", imem_addr, 32'h0000_0080);
    repeat (6) step();

`ifdef FETCH_MISALIGN_TRAP_EN
    redirect(32'h0000_0102);
    step();
    redirect_valid = 1'b0;
    sb.delete();
    sb.push_back('{pc: 32'h0000_0102, instr: 32'h0000_0013, mis: 1'b1});
    #1;
    chk("trap_no_req_n1", 32'(imem_req), 32'd0);
    step();
    #1;
    chk("trap_valid_n2", 32'(out_valid), 32'd1);
    chk("trap_mis_n2", 32'(act_mis), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      chk("trap_idle_req", 32'(imem_req), 32'd0);
      chk("trap_idle_valid", 32'(out_valid), 32'd0);
    end
    redirect(32'h0000_0200);
    step();
    redirect_valid = 1'b0;
    sb.delete();
    push_stream(32'h0000_0200, 100);
    #1;
    chk("trap_exit_req", 32'(imem_req), 32'd1);
    chk("trap_exit_addr", imem_addr, 32'h0000_0200);
`else
    redirect(32'h0000_0102);
    step();
    redirect_valid = 1'b0;
    sb.delete();
    push_stream(32'h0000_0100, 100);
    #1;
    chk("mask_req", 32'(imem_req), 32'd1);
    chk("mask_addr", imem_addr, 32'h0000_0100);
`endif
    repeat (6) step();

    // Asynchronous reset mid-stream, then restart from the reset vector.
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_pc", out_pc, 32'h0);
    chk("arst_instr", out_instr, 32'h0);
    sb.delete();
    repeat (2) step();
    do_release();
    x0 = xfers;
    repeat (6) step();
    chk("restart_throughput", 32'(xfers - x0), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
